// File: rtl/ws2812_multi_driver_pkg.sv
// Shared definitions for the multi-channel WS2812 driver: FSM states, GRB byte
// offsets within an LED, and default bit timing for a 10 MHz clock.
package ws2812_multi_driver_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HIGH,
        ST_LOW,
        ST_LATCH
    } state_e;

    // Byte order inside one LED as the strip expects it on the wire.
    localparam int OFS_G         = 0;
    localparam int OFS_R         = 1;
    localparam int OFS_B         = 2;
    localparam int BYTES_PER_LED = 3;

    localparam int DEF_T0H    = 4;
    localparam int DEF_T1H    = 8;
    localparam int DEF_TBIT   = 13;
    localparam int DEF_TRESET = 500;

endpackage

// File: rtl/ws2812_bit_timer.sv
// Shared bit-period counter for all channels; flags the end of a short high,
// the end of a long high and the end of the full bit period.
module ws2812_bit_timer #(
    parameter int T0H  = 4,
    parameter int T1H  = 8,
    parameter int TBIT = 13
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic hi0_end,
    output logic hi1_end,
    output logic bit_end
);

    localparam int CW = (TBIT > 1) ? $clog2(TBIT) : 1;

    logic [CW-1:0] cnt;

    assign hi0_end = run && (cnt == CW'(T0H - 1));
    assign hi1_end = run && (cnt == CW'(T1H - 1));
    assign bit_end = run && (cnt == CW'(TBIT - 1));

    // Restarts at every bit boundary, so it never wraps inside a bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ws2812_multi_driver.sv
// Multi-channel WS2812 strip driver: byte-addressed GRB frame buffer, all
// channels shifted out in parallel MSB first, followed by a latch gap.
module ws2812_multi_driver
    import ws2812_multi_driver_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int LED_CNT  = 11,
    parameter int T0H      = DEF_T0H,
    parameter int T1H      = DEF_T1H,
    parameter int TBIT     = DEF_TBIT,
    parameter int TRESET   = DEF_TRESET,
    parameter int AW       = $clog2(CHANNELS * LED_CNT * 3)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [7:0]          wr_data,
    output logic                wr_err,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [CHANNELS-1:0] led_o
);

    localparam int BYTES_PER_CH = LED_CNT * BYTES_PER_LED;
    localparam int DEPTH        = CHANNELS * BYTES_PER_CH;
    localparam int AW1          = AW + 1;
    localparam int LW           = (LED_CNT > 1) ? $clog2(LED_CNT) : 1;
    localparam int LTW          = $clog2(TRESET + 1);

    localparam logic [AW:0]     DEPTH_V  = AW1'(DEPTH);
    localparam logic [LW-1:0]   LAST_LED = LW'(LED_CNT - 1);
    localparam logic [LTW-1:0]  LAT_LAST = LTW'(TRESET - 1);
    localparam logic [1:0]      COL_G    = 2'(OFS_G);
    localparam logic [1:0]      COL_R    = 2'(OFS_R);
    localparam logic [1:0]      COL_B    = 2'(OFS_B);

    state_e         state, state_nxt;
    logic [7:0]     mem   [DEPTH];
    logic [7:0]     shreg [CHANNELS];
    logic [LW-1:0]  led_idx;
    logic [1:0]     col;
    logic [2:0]     bit_idx;
    logic [LTW-1:0] lat_cnt;
    logic [AW-1:0]  boff;

    logic run, hi0_end, hi1_end, bit_end;
    logic wr_ok, start_ok, last_byte, lat_end, next_bit;

    assign wr_ok     = wr_en && (state == ST_IDLE) && ({1'b0, wr_addr} < DEPTH_V);
    assign start_ok  = start && (state == ST_IDLE);
    assign last_byte = (led_idx == LAST_LED) && (col == COL_B);
    assign lat_end   = (state == ST_LATCH) && (lat_cnt == LAT_LAST);
    assign run       = (state == ST_HIGH) || (state == ST_LOW);
    assign next_bit  = (state == ST_LOW) && bit_end && (bit_idx != 3'd0);
    assign boff      = AW'(led_idx) * AW'(BYTES_PER_LED) + AW'(col);

    ws2812_bit_timer #(
        .T0H  (T0H),
        .T1H  (T1H),
        .TBIT (TBIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .hi0_end (hi0_end),
        .hi1_end (hi1_end),
        .bit_end (bit_end)
    );

    // Frame buffer is deliberately not reset; software rewrites it before use.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_HIGH;
            ST_HIGH:  if (hi1_end) state_nxt = ST_LOW;
            ST_LOW: begin
                if (bit_end) begin
                    if (bit_idx != 3'd0) begin
                        state_nxt = ST_HIGH;
                    end else if (last_byte) begin
                        state_nxt = ST_LATCH;
                    end else begin
                        state_nxt = ST_LOAD;
                    end
                end
            end
            ST_LATCH: if (lat_end) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            wr_err  <= 1'b0;
            led_idx <= '0;
            col     <= COL_G;
            bit_idx <= 3'd0;
            lat_cnt <= '0;
        end else begin
            wr_err  <= wr_en && !wr_ok;
            done    <= lat_end;
            lat_cnt <= (state == ST_LATCH) ? lat_cnt + 1'b1 : '0;

            if (start_ok) begin
                busy <= 1'b1;
            end else if (lat_end) begin
                busy <= 1'b0;
            end

            if (state == ST_IDLE) begin
                led_idx <= '0;
                col     <= COL_G;
            end

            // bit_idx wraps after bit 0 but the next LOAD reloads it anyway.
            if (state == ST_LOAD) begin
                bit_idx <= 3'd7;
            end else if (state == ST_LOW && bit_end) begin
                bit_idx <= bit_idx - 1'b1;
                if (bit_idx == 3'd0) begin
                    if (col == COL_B) begin
                        col     <= COL_G;
                        led_idx <= led_idx + 1'b1;
                    end else begin
                        col <= (col == COL_G) ? COL_R : COL_B;
                    end
                end
            end
        end
    end

    // Every line rises together at bit start; a 0-bit line drops at the short
    // mark, all lines drop at the long mark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_o <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                shreg[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (state == ST_LOAD) begin
                    shreg[c] <= mem[AW'(c * BYTES_PER_CH) + boff];
                    led_o[c] <= 1'b1;
                end else if (next_bit) begin
                    shreg[c] <= {shreg[c][6:0], 1'b0};
                    led_o[c] <= 1'b1;
                end else if (state == ST_HIGH && (hi1_end || (hi0_end && !shreg[c][7]))) begin
                    led_o[c] <= 1'b0;
                end
            end
        end
    end

endmodule
